dsp_acq_ctrl: RTL and testbench
===============================

// Module: dsp_acq_ctrl
// PURPOSE
//  Sequences the DSP sample path: gates the AD sample stream into framed, decimated captures
//  toward the state machine (sm_*). Frame start, trigger delay, length and decimation are
//  configured over the fx bus at this device's address window. Sits in dsp_top between ad_* and sm_*.
// PARAMETERS
//  DW     16  sample width
//  CNT_W  16  width of delay/length counters (registers hold CNT_W bits, two bytes each)
// PORTS
//  clk_sys    in   1      system clock; all logic on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  dev_id     in   6      device id; window hit when fx_*addr[21:16]==dev_id
//  fx_wr      in   1      fx write strobe (one cycle)
//  fx_waddr   in   22     fx write address
//  fx_data    in   8      fx write data
//  fx_rd      in   1      fx read strobe (one cycle)
//  fx_raddr   in   22     fx read address
//  fx_q       out  8      fx read data, valid cycle after fx_rd; 0 when not hit
//  ad_data    in   DW     AD sample
//  ad_vld     in   1      AD sample valid (single-cycle, may be back-to-back)
//  sm_data    out  DW     captured sample
//  sm_vld     out  1      captured sample valid
//  sm_sof     out  1      first sample of frame (with sm_vld)
//  sm_eof     out  1      last sample of frame (with sm_vld)
//  busy       out  1      high in DELAY or CAPTURE
//  frame_done out  1      one-cycle pulse when a frame completes normally
// BEHAVIOUR
//  Reset: all outputs 0; regs DELAY=0, LEN=0, DECIM=0, CONT=0; STATUS=0; state IDLE.
//  Regs (addr[15:0]): 0x0100 CTRL wo {b0 start, b1 stop, b2 cont(sticky)}; 0x0101/0x0102 DELAY lo/hi;
//   0x0103/0x0104 LEN lo/hi; 0x0105 DECIM; 0x0106 STATUS ro {b0 busy, b1 ign_start, b2 aborted};
//   STATUS read clears b1,b2. Unmapped read -> 0x00; unmapped write ignored. start/stop self-clear.
//  FSM: IDLE -start-> DELAY (dly_cnt=DELAY) ; DELAY: each ad_vld decrements; at 0 -> CAPTURE
//   (DELAY=0 goes straight to CAPTURE next cycle) ; CAPTURE: dec_cnt counts ad_vld 0..DECIM, sample
//   passed when dec_cnt==0 (first valid in CAPTURE always passed); len_cnt counts passed samples;
//   LEN-th passed sample carries sm_eof -> DONE ; DONE: 1 cycle, frame_done=1; CONT=1 -> DELAY else IDLE.
//  LEN=0: start -> DELAY -> DONE without any sm_vld; frame_done still pulses.
//  LEN=1: single sample with sm_sof=sm_eof=1.
//  Latency: sm_* registered, one clk_sys after the accepted ad_vld; sm_data holds last value otherwise.
//  Config writes while busy take effect at next frame start (shadowed at start).
//  start while busy: ignored, sets ign_start. Start accepted in IDLE or DONE.
//  stop: from any state -> IDLE next cycle; no sm_eof, no frame_done; sets aborted if busy; clears CONT.
//  start and stop same write: stop wins. Last-sample ad_vld same cycle as stop: sample not emitted.
//  Mid-frame reset: immediate IDLE, outputs 0, regs to reset values.
//  Counters never wrap: DELAY/LEN max 2^CNT_W-1 handled exactly.
// STRUCTURE
//  Shared include dsp_acq_defs.vh: register offsets, CTRL/STATUS bit indices, state encodings.
//  Sub-module dsp_acq_regs: fx decode, config regs/shadows, STATUS, fx_q mux; top holds FSM + counters.
// TESTING
//  DELAY=2, LEN=4, DECIM=0, start, 10 back-to-back ad_vld (data 1..10) -> sm_data 3,4,5,6; sof on 3, eof on 6, frame_done once.
//  DECIM=2, DELAY=0, LEN=3, data 1..12 -> sm_data 1,4,7; eof on 7; busy falls after DONE.
//  LEN=0, start -> no sm_vld, frame_done one cycle after DELAY expiry.
//  Start during CAPTURE -> ignored, STATUS read = 0x03, second read = 0x01.
//  Stop mid-frame after 2 of 5 samples -> no eof/frame_done, STATUS b2=1, state IDLE.
//  CONT=1, LEN=2 -> back-to-back frames with sof/eof per frame; fx read at other dev_id -> fx_q=0.

Source files
------------

// File: rtl/dsp_acq_ctrl_pkg.sv
// Shared definitions for the DSP acquisition controller: fx register map,
// CTRL/STATUS bit positions and FSM state encoding.
package dsp_acq_ctrl_pkg;

  localparam logic [15:0] REG_CTRL     = 16'h0100;
  localparam logic [15:0] REG_DELAY_LO = 16'h0101;
  localparam logic [15:0] REG_DELAY_HI = 16'h0102;
  localparam logic [15:0] REG_LEN_LO   = 16'h0103;
  localparam logic [15:0] REG_LEN_HI   = 16'h0104;
  localparam logic [15:0] REG_DECIM    = 16'h0105;
  localparam logic [15:0] REG_STATUS   = 16'h0106;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CONT  = 2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_IGN   = 1;
  localparam int STAT_ABORT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } acq_state_t;

  function automatic logic state_busy(input acq_state_t s);
    return (s == ST_DELAY) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/dsp_acq_ctrl_regs.sv
// fx bus decode for the acquisition controller: config registers, per-frame
// shadows, sticky STATUS flags and the registered read-data mux.
module dsp_acq_ctrl_regs
  import dsp_acq_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [5:0]       dev_id,
  input  logic             fx_wr,
  input  logic [21:0]      fx_waddr,
  input  logic [7:0]       fx_data,
  input  logic             fx_rd,
  input  logic [21:0]      fx_raddr,
  output logic [7:0]       fx_q,
  input  logic             busy,
  input  logic             frame_load,
  output logic             start,
  output logic             stop,
  output logic             cont,
  output logic [CNT_W-1:0] cfg_delay,
  output logic [CNT_W-1:0] len_sh,
  output logic [7:0]       decim_sh
);

  logic [15:0] delay_r;
  logic [15:0] len_r;
  logic [7:0]  decim_r;
  logic        ign_start;
  logic        aborted;
  logic        wr_hit;
  logic        rd_hit;
  logic        ctrl_wr;
  logic        status_rd;
  logic [7:0]  rd_mux;

  assign wr_hit    = fx_wr && (fx_waddr[21:16] == dev_id);
  assign rd_hit    = fx_rd && (fx_raddr[21:16] == dev_id);
  assign ctrl_wr   = wr_hit && (fx_waddr[15:0] == REG_CTRL);
  assign status_rd = rd_hit && (fx_raddr[15:0] == REG_STATUS);

  // start and stop are single-cycle strobes; stop overrides start in one write
  assign stop      = ctrl_wr && fx_data[CTRL_STOP];
  assign start     = ctrl_wr && fx_data[CTRL_START] && !fx_data[CTRL_STOP];
  assign cfg_delay = delay_r[CNT_W-1:0];

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      delay_r <= '0;
      len_r   <= '0;
      decim_r <= '0;
    end else if (wr_hit) begin
      case (fx_waddr[15:0])
        REG_DELAY_LO: delay_r[7:0]  <= fx_data;
        REG_DELAY_HI: delay_r[15:8] <= fx_data;
        REG_LEN_LO:   len_r[7:0]    <= fx_data;
        REG_LEN_HI:   len_r[15:8]   <= fx_data;
        REG_DECIM:    decim_r       <= fx_data;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cont <= 1'b0;
    end else if (stop) begin
      cont <= 1'b0;
    end else if (ctrl_wr) begin
      cont <= fx_data[CTRL_CONT];
    end
  end

  // A flag raised in the same cycle as a STATUS read survives the clear
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      ign_start <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      if (status_rd) begin
        ign_start <= 1'b0;
        aborted   <= 1'b0;
      end
      if (start && busy) ign_start <= 1'b1;
      if (stop && busy)  aborted   <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      len_sh   <= '0;
      decim_sh <= '0;
    end else if (frame_load) begin
      len_sh   <= len_r[CNT_W-1:0];
      decim_sh <= decim_r;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (fx_raddr[15:0])
      REG_DELAY_LO: rd_mux = delay_r[7:0];
      REG_DELAY_HI: rd_mux = delay_r[15:8];
      REG_LEN_LO:   rd_mux = len_r[7:0];
      REG_LEN_HI:   rd_mux = len_r[15:8];
      REG_DECIM:    rd_mux = decim_r;
      REG_STATUS: begin
        rd_mux[STAT_BUSY]  = busy;
        rd_mux[STAT_IGN]   = ign_start;
        rd_mux[STAT_ABORT] = aborted;
      end
      default:      rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      fx_q <= 8'h00;
    end else begin
      fx_q <= rd_hit ? rd_mux : 8'h00;
    end
  end

endmodule

// File: rtl/dsp_acq_ctrl.sv
// Acquisition sequencer: frames the AD sample stream into delayed, decimated,
// fixed-length captures toward the state machine. Holds the FSM and counters.
module dsp_acq_ctrl
  import dsp_acq_ctrl_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic [5:0]    dev_id,
  input  logic          fx_wr,
  input  logic [21:0]   fx_waddr,
  input  logic [7:0]    fx_data,
  input  logic          fx_rd,
  input  logic [21:0]   fx_raddr,
  output logic [7:0]    fx_q,
  input  logic [DW-1:0] ad_data,
  input  logic          ad_vld,
  output logic [DW-1:0] sm_data,
  output logic          sm_vld,
  output logic          sm_sof,
  output logic          sm_eof,
  output logic          busy,
  output logic          frame_done,
  output logic [1:0]    dbg_state
);

  // Stream handshake: ad_vld and sm_vld are one-cycle qualifiers with no
  // back-pressure; data is meaningful only in a cycle where its vld is high.

  acq_state_t       state_q;
  acq_state_t       state_d;
  logic             start;
  logic             stop;
  logic             cont;
  logic             frame_load;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] len_sh;
  logic [7:0]       decim_sh;
  logic [CNT_W-1:0] dly_cnt;
  logic [CNT_W-1:0] len_cnt;
  logic [7:0]       dec_cnt;
  logic             emit;
  logic             emit_sof;
  logic             emit_eof;

  dsp_acq_ctrl_regs #(.CNT_W(CNT_W)) u_regs (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .dev_id     (dev_id),
    .fx_wr      (fx_wr),
    .fx_waddr   (fx_waddr),
    .fx_data    (fx_data),
    .fx_rd      (fx_rd),
    .fx_raddr   (fx_raddr),
    .fx_q       (fx_q),
    .busy       (busy),
    .frame_load (frame_load),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
    .cfg_delay  (cfg_delay),
    .len_sh     (len_sh),
    .decim_sh   (decim_sh)
  );

  assign busy       = state_busy(state_q);
  assign frame_done = (state_q == ST_DONE);
  assign dbg_state  = state_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_load = 1'b0;
    emit       = 1'b0;
    emit_sof   = 1'b0;
    emit_eof   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DELAY;
          frame_load = 1'b1;
        end
      end
      ST_DELAY: begin
        // The sample that brings the count to zero is still consumed by the delay
        if ((dly_cnt == '0) || (ad_vld && (dly_cnt == CNT_W'(1)))) begin
          state_d = (len_sh == '0) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (ad_vld && (dec_cnt == 8'd0)) begin
          emit     = 1'b1;
          emit_sof = (len_cnt == '0);
          emit_eof = (len_cnt == len_sh - CNT_W'(1));
          if (emit_eof) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start || cont) begin
          state_d    = ST_DELAY;
          frame_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d    = ST_IDLE;
      frame_load = 1'b0;
      emit       = 1'b0;
      emit_sof   = 1'b0;
      emit_eof   = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      dly_cnt <= '0;
      dec_cnt <= '0;
      len_cnt <= '0;
    end else begin
      if (frame_load) begin
        dly_cnt <= cfg_delay;
      end else if ((state_q == ST_DELAY) && ad_vld && (dly_cnt != '0)) begin
        dly_cnt <= dly_cnt - CNT_W'(1);
      end
      if (state_q != ST_CAPTURE) begin
        dec_cnt <= '0;
        len_cnt <= '0;
      end else begin
        if (ad_vld) dec_cnt <= (dec_cnt == decim_sh) ? 8'd0 : dec_cnt + 8'd1;
        if (emit)   len_cnt <= len_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sm_data <= '0;
      sm_vld  <= 1'b0;
      sm_sof  <= 1'b0;
      sm_eof  <= 1'b0;
    end else begin
      sm_vld <= emit;
      sm_sof <= emit_sof;
      sm_eof <= emit_eof;
      if (emit) sm_data <= ad_data;
    end
  end

endmodule

// File: tb/tb_dsp_acq_ctrl.sv
// Bench for dsp_acq_ctrl: directed frame scenarios; a monitor checks the sm_*
// stream and fx read data against expected queues filled by the stimulus.
module tb_dsp_acq_ctrl;

  localparam int DW = 16;
  localparam logic [5:0]  DEV      = 6'd5;
  localparam logic [5:0]  OTHER    = 6'd6;
  localparam logic [15:0] A_CTRL   = 16'h0100;
  localparam logic [15:0] A_DLY_LO = 16'h0101;
  localparam logic [15:0] A_DLY_HI = 16'h0102;
  localparam logic [15:0] A_LEN_LO = 16'h0103;
  localparam logic [15:0] A_LEN_HI = 16'h0104;
  localparam logic [15:0] A_DECIM  = 16'h0105;
  localparam logic [15:0] A_STATUS = 16'h0106;
  localparam logic [1:0]  S_IDLE = 2'd0, S_DELAY = 2'd1, S_CAPT = 2'd2, S_DONE = 2'd3;

  // ---------------- clock / reset ----------------
  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          fx_wr = 1'b0;
  logic [21:0]   fx_waddr = '0;
  logic [7:0]    fx_data = '0;
  logic          fx_rd = 1'b0;
  logic [21:0]   fx_raddr = '0;
  logic [7:0]    fx_q;
  logic [DW-1:0] ad_data = '0;
  logic          ad_vld = 1'b0;
  logic [DW-1:0] sm_data;
  logic          sm_vld, sm_sof, sm_eof, busy, frame_done;
  logic [1:0]    dbg_state;

  always #5 clk_sys = ~clk_sys;

  dsp_acq_ctrl #(.DW(DW), .CNT_W(16)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .dev_id     (DEV),
    .fx_wr      (fx_wr),
    .fx_waddr   (fx_waddr),
    .fx_data    (fx_data),
    .fx_rd      (fx_rd),
    .fx_raddr   (fx_raddr),
    .fx_q       (fx_q),
    .ad_data    (ad_data),
    .ad_vld     (ad_vld),
    .sm_data    (sm_data),
    .sm_vld     (sm_vld),
    .sm_sof     (sm_sof),
    .sm_eof     (sm_eof),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [DW+1:0] exp_q[$];
  logic [7:0]    rd_exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            fd_cnt = 0;
  int            fd_base = 0;
  logic          rd_d1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk_sys) rd_d1 <= fx_rd;

  always @(negedge clk_sys) begin
    logic [DW+1:0] e;
    logic [7:0]    r;
    if (sm_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sm_unexpected: got sof=%0b eof=%0b data=0x%0h expected no sample",
                 sm_sof, sm_eof, sm_data);
      end else begin
        e = exp_q.pop_front();
        check("sm_sample{sof,eof,data}", 32'({sm_sof, sm_eof, sm_data}), 32'(e));
      end
    end
    if (frame_done) fd_cnt++;
    if (rd_d1) begin
      if (rd_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL fx_read_unexpected: got 0x%0h expected no read", fx_q);
      end else begin
        r = rd_exp_q.pop_front();
        check("fx_q", 32'(fx_q), 32'(r));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fx_write(input logic [15:0] a, input logic [7:0] d);
    fx_wr = 1'b1; fx_waddr = {DEV, a}; fx_data = d;
    tick();
    fx_wr = 1'b0;
  endtask

  task automatic fx_read(input logic [5:0] id, input logic [15:0] a, input logic [7:0] e);
    fx_rd = 1'b1; fx_raddr = {id, a};
    rd_exp_q.push_back(e);
    tick();
    fx_rd = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    ad_vld = 1'b1; ad_data = d;
    tick();
    ad_vld = 1'b0;
  endtask

  task automatic expect_sm(input logic [DW-1:0] d, input logic sof, input logic eof);
    exp_q.push_back({sof, eof, d});
  endtask

  task automatic cfg(input logic [15:0] dly, input logic [15:0] len, input logic [7:0] dec);
    fx_write(A_DLY_LO, dly[7:0]);
    fx_write(A_DLY_HI, dly[15:8]);
    fx_write(A_LEN_LO, len[7:0]);
    fx_write(A_LEN_HI, len[15:8]);
    fx_write(A_DECIM, dec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    idle(3);
    check("reset_outputs", 32'({sm_vld, sm_sof, sm_eof, busy, frame_done, fx_q, sm_data}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    tick();
    fx_read(DEV, A_LEN_LO, 8'h00);
    fx_read(DEV, A_STATUS, 8'h00);

    // DELAY=2 LEN=4: first two samples absorbed by the delay
    cfg(16'd2, 16'd4, 8'd0);
    fd_base = fd_cnt;
    expect_sm(16'd3, 1'b1, 1'b0);
    expect_sm(16'd4, 1'b0, 1'b0);
    expect_sm(16'd5, 1'b0, 1'b0);
    expect_sm(16'd6, 1'b0, 1'b1);
    fx_write(A_CTRL, 8'h01);
    check("t1_state_delay", 32'(dbg_state), 32'(S_DELAY));
    for (int i = 1; i <= 10; i++) send(DW'(i));
    idle(2);
    check("t1_frame_done_count", 32'(fd_cnt - fd_base), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_state_idle", 32'(dbg_state), 32'(S_IDLE));

    // DECIM=2 DELAY=0 LEN=3
    cfg(16'd0, 16'd3, 8'd2);
    fd_base = fd_cnt;
    expect_sm(16'd1, 1'b1, 1'b0);
    expect_sm(16'd4, 1'b0, 1'b0);
    expect_sm(16'd7, 1'b0, 1'b1);
    fx_write(A_CTRL, 8'h01);
    idle(2);
    check("t2_busy_capture", 32'(busy), 32'd1);
    check("t2_state_capture", 32'(dbg_state), 32'(S_CAPT));
    for (int i = 1; i <= 12; i++) send(DW'(i));
    idle(2);
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_frame_done_count", 32'(fd_cnt - fd_base), 32'd1);

    // LEN=0: DELAY then DONE, no samples
    fx_write(A_LEN_LO, 8'h00);
    fd_base = fd_cnt;
    fx_write(A_CTRL, 8'h01);
    check("t3_state_delay", 32'({dbg_state, frame_done}), 32'({S_DELAY, 1'b0}));
    tick();
    check("t3_state_done", 32'({dbg_state, frame_done}), 32'({S_DONE, 1'b1}));
    tick();
    check("t3_state_idle", 32'({dbg_state, frame_done}), 32'({S_IDLE, 1'b0}));
    check("t3_frame_done_count", 32'(fd_cnt - fd_base), 32'd1);

    // start during CAPTURE is ignored and flagged
    cfg(16'd0, 16'd5, 8'd0);
    fd_base = fd_cnt;
    expect_sm(16'd1, 1'b1, 1'b0);
    expect_sm(16'd2, 1'b0, 1'b0);
    fx_write(A_CTRL, 8'h01);
    idle(2);
    send(16'd1);
    send(16'd2);
    fx_write(A_CTRL, 8'h01);
    check("t4_state_still_capture", 32'(dbg_state), 32'(S_CAPT));
    fx_read(DEV, A_STATUS, 8'h03);
    fx_read(DEV, A_STATUS, 8'h01);
    expect_sm(16'd3, 1'b0, 1'b0);
    expect_sm(16'd4, 1'b0, 1'b0);
    expect_sm(16'd5, 1'b0, 1'b1);
    send(16'd3);
    send(16'd4);
    send(16'd5);
    idle(2);
    fx_read(DEV, A_STATUS, 8'h00);
    check("t4_frame_done_count", 32'(fd_cnt - fd_base), 32'd1);

    // stop after 2 of 5 samples
    fd_base = fd_cnt;
    expect_sm(16'd10, 1'b1, 1'b0);
    expect_sm(16'd20, 1'b0, 1'b0);
    fx_write(A_CTRL, 8'h01);
    idle(2);
    send(16'd10);
    send(16'd20);
    fx_write(A_CTRL, 8'h02);
    idle(2);
    check("t5_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_frame_done_count", 32'(fd_cnt - fd_base), 32'd0);
    fx_read(DEV, A_STATUS, 8'h04);
    fx_read(DEV, A_STATUS, 8'h00);

    // stop in the same cycle as the would-be last sample
    fx_write(A_LEN_LO, 8'd3);
    fd_base = fd_cnt;
    expect_sm(16'd10, 1'b1, 1'b0);
    expect_sm(16'd20, 1'b0, 1'b0);
    fx_write(A_CTRL, 8'h01);
    idle(2);
    send(16'd10);
    send(16'd20);
    ad_vld = 1'b1; ad_data = 16'd30;
    fx_wr = 1'b1; fx_waddr = {DEV, A_CTRL}; fx_data = 8'h02;
    tick();
    ad_vld = 1'b0; fx_wr = 1'b0;
    idle(2);
    check("t5b_frame_done_count", 32'(fd_cnt - fd_base), 32'd0);
    fx_read(DEV, A_STATUS, 8'h04);
    fx_write(A_CTRL, 8'h03);
    check("t5b_start_stop_stop_wins", 32'(dbg_state), 32'(S_IDLE));
    tick();
    fx_read(DEV, A_STATUS, 8'h00);

    // CONT=1 LEN=2: back-to-back frames
    fx_write(A_LEN_LO, 8'd2);
    fd_base = fd_cnt;
    for (int i = 1; i <= 6; i++) expect_sm(DW'(i), (i % 2) == 1, (i % 2) == 0);
    fx_write(A_CTRL, 8'h05);
    idle(2);
    for (int i = 1; i <= 6; i++) begin
      send(DW'(i));
      idle(3);
    end
    check("t6_state_recaptured", 32'(dbg_state), 32'(S_CAPT));
    fx_write(A_CTRL, 8'h02);
    check("t6_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("t6_frame_done_count", 32'(fd_cnt - fd_base), 32'd3);
    fx_read(DEV, A_STATUS, 8'h04);
    fx_read(OTHER, A_LEN_LO, 8'h00);
    fx_read(DEV, A_LEN_LO, 8'h02);
    fx_read(DEV, 16'h0107, 8'h00);
    fx_read(DEV, A_CTRL, 8'h00);

    // LEN=1: single sample carries sof and eof
    fx_write(A_LEN_LO, 8'd1);
    fd_base = fd_cnt;
    expect_sm(16'h0077, 1'b1, 1'b1);
    fx_write(A_CTRL, 8'h01);
    idle(2);
    send(16'h0077);
    send(16'h0078);
    idle(2);
    check("t7_frame_done_count", 32'(fd_cnt - fd_base), 32'd1);
    check("t7_state_idle", 32'(dbg_state), 32'(S_IDLE));

    // mid-frame reset
    fx_write(A_LEN_LO, 8'd5);
    expect_sm(16'h0011, 1'b1, 1'b0);
    fx_write(A_CTRL, 8'h01);
    idle(2);
    send(16'h0011);
    fx_write(A_DLY_HI, 8'hAB);
    fx_read(DEV, A_DLY_HI, 8'hAB);
    tick();
    rst = 1'b1;
    #2;
    check("t8_reset_outputs", 32'({sm_vld, sm_sof, sm_eof, busy, frame_done, fx_q, sm_data}), 32'd0);
    check("t8_reset_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    rst = 1'b0;
    tick();
    fx_read(DEV, A_DLY_HI, 8'h00);
    fx_read(DEV, A_LEN_LO, 8'h00);
    fx_read(DEV, A_STATUS, 8'h00);
    idle(3);

    check("sm_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
